// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM command bus arbiter with periodic refresh timer
//
// Purpose: shares the single SDRAM command/address bus between the init
// sequencer, the auto-refresh engine, the write engine and the read engine.
// It also runs the refresh interval timer and raises aref_req so the write
// and read engines close their bursts at a burst boundary.
//
// Ports:
//   S_CLK, RST_N                 clock, synchronous active-low reset
//   init_done/init_cmd/init_addr init sequencer handshake and command
//   aref_en/aref_end/aref_cmd/aref_addr      refresh engine grant/handshake
//   aref_req                     refresh pending, seen by write/read engines
//   write_req/write_en/write_end/write_cmd/write_addr  write engine
//   read_req/read_en/read_end/read_cmd/read_addr        read engine
//   sdram_cmd/sdram_addr         muxed command/address to the pin driver

module sdram_arbiter #(
    parameter int AREF_PERIOD = 1560,
    parameter int CNT_W       = 11
) (
    input  logic             S_CLK,
    input  logic             RST_N,
    input  logic             init_done,
    input  logic [4:0]       init_cmd,
    input  logic [11:0]      init_addr,
    output logic             aref_en,
    input  logic             aref_end,
    input  logic [4:0]       aref_cmd,
    input  logic [11:0]      aref_addr,
    output logic             aref_req,
    input  logic             write_req,
    output logic             write_en,
    input  logic             write_end,
    input  logic [4:0]       write_cmd,
    input  logic [11:0]      write_addr,
    input  logic             read_req,
    output logic             read_en,
    input  logic             read_end,
    input  logic [4:0]       read_cmd,
    input  logic [11:0]      read_addr,
    output logic [4:0]       sdram_cmd,
    output logic [11:0]      sdram_addr
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ARBIT = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_MAX = CNT_W'(AREF_PERIOD - 1);
    localparam logic [4:0]       CMD_NOP   = 5'b10111;
    localparam logic [11:0]      ADDR_NOP  = 12'h400;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             aref_req_q, aref_req_d;
    logic             last_wr_q, last_wr_d;
    logic             timer_expire;

    always_ff @(posedge S_CLK) begin
        if (!RST_N) begin
            state_q    <= S_INIT;
            timer_q    <= '0;
            aref_req_q <= 1'b0;
            last_wr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            aref_req_q <= aref_req_d;
            last_wr_q  <= last_wr_d;
        end
    end

    // Refresh timer: frozen at zero during init, free-running afterwards.
    assign timer_expire = (state_q != S_INIT) && (timer_q == TIMER_MAX);

    always_comb begin
        timer_d    = timer_q;
        aref_req_d = aref_req_q;
        if (state_q == S_INIT) begin
            timer_d = '0;
        end else if (timer_expire) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + CNT_W'(1);
        end
        // Pending request is consumed when ARBIT hands the bus to refresh.
        // An expiry on the same edge re-arms it; a repeat expiry while
        // still pending merges into the existing request.
        if (state_q == S_ARBIT && aref_req_q) begin
            aref_req_d = 1'b0;
        end
        if (timer_expire) begin
            aref_req_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        case (state_q)
            S_INIT: begin
                if (init_done) begin
                    state_d = S_ARBIT;
                end
            end
            S_ARBIT: begin
                if (aref_req_q) begin
                    state_d = S_AREF;
                end else if (write_req && read_req) begin
                    // Round-robin between the two data engines.
                    if (last_wr_q) begin
                        state_d   = S_READ;
                        last_wr_d = 1'b0;
                    end else begin
                        state_d   = S_WRITE;
                        last_wr_d = 1'b1;
                    end
                end else if (write_req) begin
                    state_d   = S_WRITE;
                    last_wr_d = 1'b1;
                end else if (read_req) begin
                    state_d   = S_READ;
                    last_wr_d = 1'b0;
                end
            end
            S_AREF: begin
                if (aref_end) begin
                    state_d = S_ARBIT;
                end
            end
            S_WRITE: begin
                if (write_end) begin
                    state_d = S_ARBIT;
                end
            end
            S_READ: begin
                if (read_end) begin
                    state_d = S_ARBIT;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Grants are decoded from registered state, so they are one-hot by
    // construction; a pending refresh asks the data engines to wrap up.
    assign aref_req = aref_req_q;
    assign aref_en  = (state_q == S_AREF);
    assign write_en = (state_q == S_WRITE) && write_req && !aref_req_q;
    assign read_en  = (state_q == S_READ) && read_req && !aref_req_q;

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = ADDR_NOP;
        case (state_q)
            S_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            S_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            S_WRITE: begin
                sdram_cmd  = write_cmd;
                sdram_addr = write_addr;
            end
            S_READ: begin
                sdram_cmd  = read_cmd;
                sdram_addr = read_addr;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_addr = ADDR_NOP;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed self-checking bench for sdram_arbiter

module tb_sdram_arbiter;

    localparam logic [4:0]  NOP    = 5'b10111;
    localparam logic [11:0] NOP_A  = 12'h400;
    localparam logic [4:0]  AR_C   = 5'b00001;
    localparam logic [11:0] AR_A   = 12'h111;
    localparam logic [4:0]  WR_C   = 5'b00010;
    localparam logic [11:0] WR_A   = 12'h222;
    localparam logic [4:0]  RD_C   = 5'b00011;
    localparam logic [11:0] RD_A   = 12'h333;

    logic        S_CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        init_done = 1'b0;
    logic [4:0]  init_cmd = 5'b01000;
    logic [11:0] init_addr = 12'h0ab;
    logic        aref_en;
    logic        aref_end = 1'b0;
    logic        aref_req;
    logic        write_req = 1'b0;
    logic        write_en;
    logic        write_end = 1'b0;
    logic        read_req = 1'b0;
    logic        read_en;
    logic        read_end = 1'b0;
    logic [4:0]  sdram_cmd;
    logic [11:0] sdram_addr;

    int total = 0;
    int bad = 0;
    int t = 0;

    sdram_arbiter #(.AREF_PERIOD(64), .CNT_W(11)) dut (
        .S_CLK(S_CLK), .RST_N(RST_N),
        .init_done(init_done), .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_en(aref_en), .aref_end(aref_end), .aref_cmd(AR_C), .aref_addr(AR_A),
        .aref_req(aref_req),
        .write_req(write_req), .write_en(write_en), .write_end(write_end),
        .write_cmd(WR_C), .write_addr(WR_A),
        .read_req(read_req), .read_en(read_en), .read_end(read_end),
        .read_cmd(RD_C), .read_addr(RD_A),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr)
    );

    always #5 S_CLK = ~S_CLK;

    task automatic tick();
        @(posedge S_CLK);
        #1;
        t++;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick();
        tick();
        total++;
        if ({aref_en, write_en, read_en, aref_req} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs t=%0d got=%b want=0000", t, {aref_en, write_en, read_en, aref_req});
        end
        total++;
        if ({sdram_cmd, sdram_addr} !== {init_cmd, init_addr}) begin
            bad++;
            $display("FAIL reset_mux got=%h/%h want=%h/%h", sdram_cmd, sdram_addr, init_cmd, init_addr);
        end
    endtask

    task automatic test_power_up();
        RST_N = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            init_cmd  = 5'(i);
            init_addr = 12'(i * 37);
            #1;
            total++;
            if ({sdram_cmd, sdram_addr} !== {init_cmd, init_addr}) begin
                bad++;
                $display("FAIL init_track i=%0d got=%h/%h want=%h/%h", i, sdram_cmd, sdram_addr, init_cmd, init_addr);
            end
            total++;
            if ({aref_en, write_en, read_en, aref_req} !== 4'b0000) begin
                bad++;
                $display("FAIL init_quiet i=%0d got=%b want=0000", i, {aref_en, write_en, read_en, aref_req});
            end
        end
        init_done = 1'b1;
        tick();
        t = 0;
        total++;
        if ({sdram_cmd, sdram_addr} !== {NOP, NOP_A}) begin
            bad++;
            $display("FAIL arbit_nop got=%h/%h want=%h/%h", sdram_cmd, sdram_addr, NOP, NOP_A);
        end
    endtask

    task automatic test_refresh_timing();
        while (t < 64) begin
            total++;
            if (aref_req !== 1'b0 || aref_en !== 1'b0) begin
                bad++;
                $display("FAIL early_aref t=%0d req=%b en=%b want=0/0", t, aref_req, aref_en);
            end
            tick();
        end
        total++;
        if (aref_req !== 1'b1 || aref_en !== 1'b0 || sdram_cmd !== NOP) begin
            bad++;
            $display("FAIL aref_req_64 req=%b en=%b cmd=%h want=1/0/%h", aref_req, aref_en, sdram_cmd, NOP);
        end
        tick();
        while (t < 75) begin
            total++;
            if (aref_en !== 1'b1 || aref_req !== 1'b0 || {sdram_cmd, sdram_addr} !== {AR_C, AR_A}) begin
                bad++;
                $display("FAIL aref_grant t=%0d en=%b req=%b cmd=%h want=1/0/%h", t, aref_en, aref_req, sdram_cmd, AR_C);
            end
            aref_end = (t == 74);
            tick();
        end
        aref_end = 1'b0;
        total++;
        if (aref_en !== 1'b0 || sdram_cmd !== NOP) begin
            bad++;
            $display("FAIL aref_done en=%b cmd=%h want=0/%h", aref_en, sdram_cmd, NOP);
        end
        while (t < 128) begin
            total++;
            if (aref_req !== 1'b0) begin
                bad++;
                $display("FAIL second_early t=%0d req=%b want=0", t, aref_req);
            end
            tick();
        end
        total++;
        if (aref_req !== 1'b1) begin
            bad++;
            $display("FAIL second_aref_128 req=%b want=1", aref_req);
        end
        tick();
        aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
    endtask

    task automatic test_write_preempt();
        write_req = 1'b1;
        tick();
        while (t < 192) begin
            total++;
            if (write_en !== 1'b1 || {sdram_cmd, sdram_addr} !== {WR_C, WR_A}) begin
                bad++;
                $display("FAIL write_grant t=%0d en=%b cmd=%h want=1/%h", t, write_en, sdram_cmd, WR_C);
            end
            read_end = (t == 140);
            tick();
        end
        read_end = 1'b0;
        while (t < 260) begin
            total++;
            if (write_en !== 1'b0 || aref_req !== 1'b1 || sdram_cmd !== WR_C || aref_en !== 1'b0) begin
                bad++;
                $display("FAIL write_preempted t=%0d en=%b req=%b cmd=%h want=0/1/%h", t, write_en, aref_req, sdram_cmd, WR_C);
            end
            tick();
        end
        write_end = 1'b1;
        tick();
        write_end = 1'b0;
        total++;
        if ({aref_en, write_en, read_en} !== 3'b000 || sdram_cmd !== NOP) begin
            bad++;
            $display("FAIL post_write_arbit grants=%b cmd=%h want=000/%h", {aref_en, write_en, read_en}, sdram_cmd, NOP);
        end
        tick();
        total++;
        if (aref_en !== 1'b1 || write_en !== 1'b0 || aref_req !== 1'b0 || sdram_cmd !== AR_C) begin
            bad++;
            $display("FAIL aref_over_write en=%b wen=%b req=%b cmd=%h want=1/0/0/%h", aref_en, write_en, aref_req, sdram_cmd, AR_C);
        end
        aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
        tick();
        total++;
        if (write_en !== 1'b1 || aref_req !== 1'b0 || sdram_cmd !== WR_C) begin
            bad++;
            $display("FAIL write_resume wen=%b req=%b cmd=%h want=1/0/%h (single refresh)", write_en, aref_req, sdram_cmd, WR_C);
        end
    endtask

    task automatic serve(input logic is_wr, input int n);
        for (int i = 0; i < n; i++) begin
            total++;
            if ({aref_en, write_en, read_en} !== {1'b0, is_wr, !is_wr} ||
                sdram_cmd !== (is_wr ? WR_C : RD_C)) begin
                bad++;
                $display("FAIL rr_grant t=%0d wr=%b grants=%b cmd=%h", t, is_wr, {aref_en, write_en, read_en}, sdram_cmd);
            end
            if (i == n - 1) begin
                if (is_wr) write_end = 1'b1;
                else read_end = 1'b1;
            end
            tick();
        end
        write_end = 1'b0;
        read_end  = 1'b0;
        total++;
        if ({aref_en, write_en, read_en} !== 3'b000 || sdram_cmd !== NOP) begin
            bad++;
            $display("FAIL rr_arbit t=%0d grants=%b cmd=%h want=000/%h", t, {aref_en, write_en, read_en}, sdram_cmd, NOP);
        end
        tick();
    endtask

    task automatic test_round_robin();
        read_req = 1'b1;
        serve(1'b1, 8);
        serve(1'b0, 8);
        serve(1'b1, 8);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({aref_en, write_en, read_en} !== 3'b001 || sdram_cmd !== RD_C) begin
                bad++;
                $display("FAIL rr_fourth t=%0d grants=%b cmd=%h want=001/%h", t, {aref_en, write_en, read_en}, sdram_cmd, RD_C);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_read();
        RST_N     = 1'b0;
        write_req = 1'b0;
        read_req  = 1'b0;
        tick();
        total++;
        if ({aref_en, write_en, read_en, aref_req} !== 4'b0000 ||
            {sdram_cmd, sdram_addr} !== {init_cmd, init_addr}) begin
            bad++;
            $display("FAIL mid_reset flags=%b cmd=%h want=0000/%h", {aref_en, write_en, read_en, aref_req}, sdram_cmd, init_cmd);
        end
        RST_N = 1'b1;
        tick();
        t = 0;
        total++;
        if (sdram_cmd !== NOP) begin
            bad++;
            $display("FAIL requalify cmd=%h want=%h", sdram_cmd, NOP);
        end
        while (t < 64) begin
            total++;
            if (aref_req !== 1'b0) begin
                bad++;
                $display("FAIL timer_cleared t=%0d req=%b want=0", t, aref_req);
            end
            tick();
        end
        total++;
        if (aref_req !== 1'b1) begin
            bad++;
            $display("FAIL timer_restart req=%b want=1", aref_req);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_refresh_timing();
        test_write_preempt();
        test_round_robin();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Owns the single SDRAM command/address bus and shares it between the init sequencer, the auto-refresh engine, the write engine and the read engine.
- Contains the periodic refresh timer and issues `aref_req` to the write and read engines so they end their bursts at a burst boundary.
- Sits between the four engines and the SDRAM pin driver.

Parameters:
- AREF_PERIOD, 1560, refresh interval in S_CLK cycles (15.6 us at 100 MHz).
- CNT_W, 11, width of the refresh timer; must hold AREF_PERIOD-1.

Ports:
- S_CLK  in  1  system clock
- RST_N  in  1  synchronous, active-low reset
- init_done  in  1  init sequencer finished; level, stays high
- init_cmd  in  5  init command {CKE,CS_N,RAS_N,CAS_N,WE_N}
- init_addr  in  12  init address
- aref_en  out  1  refresh grant, level
- aref_end  in  1  one-cycle pulse, refresh engine back in idle
- aref_cmd  in  5  refresh engine command
- aref_addr  in  12  refresh engine address
- aref_req  out  1  refresh pending, to write/read engines
- write_req  in  1  write engine has data (FIFO above threshold), level
- write_en  out  1  write grant; low means finish current burst
- write_end  in  1  one-cycle pulse, write engine back in idle
- write_cmd  in  5  write engine command
- write_addr  in  12  write engine address
- read_req  in  1  read request, level
- read_en  out  1  read grant; low means finish current burst
- read_end  in  1  one-cycle pulse, read engine back in idle
- read_cmd  in  5  read engine command
- read_addr  in  12  read engine address
- sdram_cmd  out  5  command to SDRAM
- sdram_addr  out  12  address to SDRAM

Behaviour:
- All flops are reset synchronously on a rising S_CLK edge with RST_N=0.
- Reset values:
  - state=INIT, timer=0, aref_req=0, last_wr=0 (read counts as last served).
  - Outputs: aref_en=write_en=read_en=0; sdram_cmd=init_cmd, sdram_addr=init_addr (INIT mux).
- States: INIT, ARBIT, AREF, WRITE, READ.
- INIT: stay until init_done=1, then go to ARBIT. The timer is held at 0 in INIT.
- Refresh timer:
  - Counts every cycle outside INIT.
  - At timer==AREF_PERIOD-1 it wraps to 0 and sets aref_req=1.
  - aref_req clears on the ARBIT->AREF transition edge.
  - If the timer expires while aref_req is already 1, aref_req stays 1; there is no second queued request.
- ARBIT (minimum 1 cycle), decided on the sampled inputs in this priority order:
  - aref_req=1 -> AREF.
  - write_req and read_req both 1 -> go to the one not served last (round-robin): last_wr=0 -> WRITE, last_wr=1 -> READ.
  - Only write_req -> WRITE.
  - Only read_req -> READ.
  - Otherwise stay in ARBIT.
  - last_wr updates on entry to WRITE (1) or READ (0).
- AREF:
  - aref_en=1.
  - On aref_end, go to ARBIT; aref_en drops in the same cycle the state leaves.
- WRITE:
  - write_en = write_req & ~aref_req (combinational from registered state/aref_req).
  - Stay until write_end, then go to ARBIT.
  - If write_en drops and later rises again before write_end, the engine may continue; the arbiter does not care.
- READ: same as WRITE, with read_req, read_en and read_end.
- A *_end pulse arriving in a state other than its own is ignored.
- Command mux (combinational from state):
  - INIT -> init_*.
  - AREF -> aref_*.
  - WRITE -> write_*.
  - READ -> read_*.
  - ARBIT -> NOP (5'b10111), address 12'h400.
- Grants are one-hot; at most one of aref_en, write_en, read_en is ever high.
- Latency from ARBIT decision to grant visible: 1 cycle (the grant is high in the first cycle of the new state).
- Simultaneous events:
  - Timer expiry in the same cycle as the ARBIT decision: aref_req is not yet visible, so the write/read grant proceeds; aref_req then forces that grant low.
  - Timer expiry during AREF: the new request is serviced next.
- Reset mid-operation returns to INIT; init_done must be re-qualified.

Test Plan:
- Power-up: hold init_done=0 for 100 cycles -> state INIT, sdram_cmd tracks init_cmd, no grants, aref_req=0. Raise init_done -> ARBIT, sdram_cmd=5'b10111, addr=12'h400.
- Refresh timing (AREF_PERIOD=64): no requests -> aref_req rises 64 cycles after leaving INIT, then aref_en next cycle. aref_end after 10 cycles -> ARBIT. Next aref_req exactly 64 cycles after the first.
- Write preempted by refresh: write_req held high, write granted. Timer expires mid-write -> write_en falls same cycle as aref_req rises. On write_end -> ARBIT -> AREF (not WRITE), then WRITE again.
- Round-robin: write_req and read_req both held high, *_end after 8 cycles each -> grant order WRITE, READ, WRITE, READ. Never two grants high at once.
- Stray/simultaneous handshake: read_end pulsed during WRITE -> ignored, state stays WRITE. Timer expiry while aref_req already 1 -> a single AREF only.
- Reset mid-READ: pull RST_N low for 1 cycle -> next edge state=INIT, all grants 0, timer=0, aref_req=0.
